find_top_bottom: RTL and testbench

// - Upstream stage of the left/right edge finders in the star-finding pipeline.
// - Raster-scans the WIDTH x HEIGHT pixel RAM (read-only, 1-cycle synchronous read).
// - Reports the top-most row, bottom-most row and horizontal midpoint of the shape.
// - Pulses top_and_bottom_found to launch the left/right edge search.

---
 rtl/find_top_bottom.sv | 172 +++++++++++++++++
 tb/tb_find_top_bottom.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/find_top_bottom.sv
// Raster-scans the pixel RAM and reports the top row, bottom row and horizontal midpoint of the shape.
// Optional early termination after the first empty row below the shape: define FIND_TB_EARLY_EXIT_EN.
module find_top_bottom #(
   parameter int X_SZ      = 3,
   parameter int Y_SZ      = 3,
   parameter int ADDR_SZ   = 6,
   parameter int COL_SZ    = 3,
   parameter int WIDTH     = 6,
   parameter int HEIGHT    = 6,
   parameter int THRESHOLD = 0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   output logic [ADDR_SZ-1:0] mem_address,
   input  logic [COL_SZ-1:0]  pix_val,
   output logic               busy,
   output logic [Y_SZ-1:0]    most_top,
   output logic [Y_SZ-1:0]    most_bottom,
   output logic [X_SZ-1:0]    mid_pix,
   output logic               shape_found,
   output logic               top_and_bottom_found,
   output logic [1:0]         fsm_state
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t          state;
   logic [X_SZ-1:0] x;
   logic [Y_SZ-1:0] y;
   logic [X_SZ-1:0] min_x;
   logic [X_SZ-1:0] max_x;

   // Coordinate of the address issued last cycle; its pixel is on pix_val now.
   logic            p_valid;
   logic [X_SZ-1:0] p_x;
   logic [Y_SZ-1:0] p_y;

   logic            hit;
   logic            first_hit;
   logic            row_end;
   logic [X_SZ-1:0] min_nxt;
   logic [X_SZ-1:0] max_nxt;
   logic [X_SZ:0]   mid_sum;

`ifdef FIND_TB_EARLY_EXIT_EN
   logic            row_hit;
   logic            empty_row_end;
`endif

   assign fsm_state = state;

   assign mem_address = (state == SCAN) ?
                        (ADDR_SZ'(y) * ADDR_SZ'(WIDTH) + ADDR_SZ'(x)) : '0;

   always_comb begin
      hit       = p_valid && (pix_val != COL_SZ'(THRESHOLD));
      first_hit = hit && !shape_found;
      row_end   = p_valid && (p_x == X_SZ'(WIDTH - 1));
      min_nxt   = min_x;
      max_nxt   = max_x;
      if (first_hit) begin
         min_nxt = p_x;
         max_nxt = p_x;
      end else if (hit) begin
         if (p_x < min_x) min_nxt = p_x;
         if (p_x > max_x) max_nxt = p_x;
      end
      // Midpoint includes the pixel being evaluated this cycle (matters in DRAIN).
      mid_sum = {1'b0, min_nxt} + {1'b0, max_nxt};
   end

`ifdef FIND_TB_EARLY_EXIT_EN
   assign empty_row_end = row_end && shape_found && !row_hit && !hit;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state                <= IDLE;
         x                    <= '0;
         y                    <= '0;
         min_x                <= '0;
         max_x                <= '0;
         p_valid              <= 1'b0;
         p_x                  <= '0;
         p_y                  <= '0;
         busy                 <= 1'b0;
         most_top             <= '0;
         most_bottom          <= '0;
         mid_pix              <= '0;
         shape_found          <= 1'b0;
         top_and_bottom_found <= 1'b0;
`ifdef FIND_TB_EARLY_EXIT_EN
         row_hit              <= 1'b0;
`endif
      end else begin
         top_and_bottom_found <= 1'b0;

         if (hit) begin
            most_bottom <= p_y;
            min_x       <= min_nxt;
            max_x       <= max_nxt;
            if (first_hit) begin
               most_top    <= p_y;
               shape_found <= 1'b1;
            end
         end

`ifdef FIND_TB_EARLY_EXIT_EN
         if (row_end)  row_hit <= 1'b0;
         else if (hit) row_hit <= 1'b1;
`endif

         case (state)
            IDLE: begin
               p_valid <= 1'b0;
               if (start) begin
                  state       <= SCAN;
                  busy        <= 1'b1;
                  x           <= '0;
                  y           <= '0;
                  shape_found <= 1'b0;
                  most_top    <= '0;
                  most_bottom <= '0;
                  mid_pix     <= '0;
                  min_x       <= '0;
                  max_x       <= '0;
`ifdef FIND_TB_EARLY_EXIT_EN
                  row_hit     <= 1'b0;
`endif
               end
            end
            SCAN: begin
               p_valid <= 1'b1;
               p_x     <= x;
               p_y     <= y;
               if (x == X_SZ'(WIDTH - 1)) begin
                  x <= '0;
                  if (y == Y_SZ'(HEIGHT - 1)) begin
                     y     <= '0;
                     state <= DRAIN;
                  end else begin
                     y <= y + 1'b1;
                  end
               end else begin
                  x <= x + 1'b1;
               end
`ifdef FIND_TB_EARLY_EXIT_EN
               if (empty_row_end) begin
                  p_valid <= 1'b0;
                  x       <= '0;
                  y       <= '0;
                  state   <= DRAIN;
               end
`endif
            end
            DRAIN: begin
               p_valid              <= 1'b0;
               mid_pix              <= mid_sum[X_SZ:1];
               top_and_bottom_found <= 1'b1;
               state                <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_find_top_bottom.sv
// Directed bench for find_top_bottom: expected results queued at start, checked when the done pulse appears.
module tb_find_top_bottom;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [5:0] mem_address;
   logic [2:0] pix_val = 3'd0;
   logic       busy;
   logic [2:0] most_top;
   logic [2:0] most_bottom;
   logic [2:0] mid_pix;
   logic       shape_found;
   logic       tbf;
   logic [1:0] fsm_state;

   logic [2:0]  mem [0:35];
   logic [25:0] exp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic        prev_tbf = 1'b0;

   find_top_bottom dut (
      .clk                  (clk),
      .resetn               (resetn),
      .start                (start),
      .mem_address          (mem_address),
      .pix_val              (pix_val),
      .busy                 (busy),
      .most_top             (most_top),
      .most_bottom          (most_bottom),
      .mid_pix              (mid_pix),
      .shape_found          (shape_found),
      .top_and_bottom_found (tbf),
      .fsm_state            (fsm_state)
   );

   // Clock, edge counter and 1-cycle synchronous RAM model
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) pix_val <= mem[mem_address];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_img();
      for (int i = 0; i < 36; i++) mem[i] = 3'd0;
   endtask

   task automatic set_pix(input int px, input int py, input int val);
      mem[py * 6 + px] = 3'(val);
   endtask

   task automatic push_exp(input int pcyc, input int found, input int top, input int bot, input int mid);
      exp_q.push_back({16'(pcyc), 1'(found), 3'(top), 3'(bot), 3'(mid)});
   endtask

   // Called #1 after a posedge; s is the number of the edge that samples start.
   task automatic start_scan(output int s);
      s = cyc + 1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic idle_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops an expectation on every done pulse
   always @(negedge clk) begin
      logic [25:0] e;
      if (resetn) begin
         if (prev_tbf) chk("pulse_width", int'(tbf), 0);
         if (tbf) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_cycle", cyc, int'(e[25:10]));
               chk("shape_found", int'(shape_found), int'(e[9]));
               chk("most_top", int'(most_top), int'(e[8:6]));
               chk("most_bottom", int'(most_bottom), int'(e[5:3]));
               chk("mid_pix", int'(mid_pix), int'(e[2:0]));
               chk("busy_in_done", int'(busy), 1);
            end
         end
         prev_tbf = tbf;
      end else begin
         prev_tbf = 1'b0;
      end
   end

   initial begin
      int s;
      resetn = 1'b0;
      start  = 1'b0;
      clear_img();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr", int'(mem_address), 0);
      chk("rst_top", int'(most_top), 0);
      chk("rst_bottom", int'(most_bottom), 0);
      chk("rst_mid", int'(mid_pix), 0);
      chk("rst_found", int'(shape_found), 0);
      chk("rst_pulse", int'(tbf), 0);
      chk("rst_state", int'(fsm_state), 0);
      resetn = 1'b1;
      idle_wait(2);

      // Single pixel at (2,3)
      clear_img();
      set_pix(2, 3, 5);
      start_scan(s);
      push_exp(s + 37, 1, 3, 3, 2);
      idle_wait(45);
      chk("hold_top", int'(most_top), 3);
      chk("idle_addr", int'(mem_address), 0);

      // Block rows 1-4, cols 1-3
      clear_img();
      for (int yy = 1; yy <= 4; yy++)
         for (int xx = 1; xx <= 3; xx++) set_pix(xx, yy, 7);
      start_scan(s);
      push_exp(s + 37, 1, 1, 4, 2);
      idle_wait(45);

      // Empty image
      clear_img();
      start_scan(s);
      push_exp(s + 37, 0, 0, 0, 0);
      idle_wait(45);

      // Opposite corners
      clear_img();
      set_pix(0, 0, 1);
      set_pix(5, 5, 3);
      start_scan(s);
      push_exp(s + 37, 1, 0, 5, 2);
      idle_wait(45);

      // Reset in the middle of a scan: no pulse, then a clean rescan
      clear_img();
      set_pix(2, 3, 5);
      start_scan(s);
      idle_wait(9);
      resetn = 1'b0;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_addr", int'(mem_address), 0);
      chk("midrst_found", int'(shape_found), 0);
      chk("midrst_pulse", int'(tbf), 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      idle_wait(45);
      start_scan(s);
      push_exp(s + 37, 1, 3, 3, 2);
      idle_wait(45);

      // start re-pulsed while busy is ignored
      clear_img();
      for (int yy = 1; yy <= 4; yy++)
         for (int xx = 1; xx <= 3; xx++) set_pix(xx, yy, 7);
      start_scan(s);
      push_exp(s + 37, 1, 1, 4, 2);
      idle_wait(4);
      chk("scan_addr", int'(mem_address), 4);
      chk("scan_busy", int'(busy), 1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      idle_wait(45);

      // start held high: back-to-back scans
      clear_img();
      set_pix(4, 0, 2);
      s = cyc + 1;
      start = 1'b1;
      push_exp(s + 37, 1, 0, 0, 4);
      push_exp(s + 39 + 37, 1, 0, 0, 4);
      idle_wait(40);
      start = 1'b0;
      idle_wait(45);

      // Shapes in rows 0-1 plus a stray pixel at (5,4)
      clear_img();
      set_pix(1, 0, 4);
      set_pix(2, 1, 4);
      set_pix(5, 4, 4);
      start_scan(s);
`ifdef FIND_TB_EARLY_EXIT_EN
      push_exp(s + 20, 1, 0, 1, 1);
`else
      push_exp(s + 37, 1, 0, 4, 3);
`endif
      idle_wait(45);

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
